// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 request/response protocol:
// command and response encodings plus the responder FSM states.
package calc1_pkg;

    localparam logic [0:3] CMD_NOP = 4'd0;
    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_SHL = 4'd5;
    localparam logic [0:3] CMD_SHR = 4'd6;

    localparam logic [0:1] RESP_NONE = 2'd0;
    localparam logic [0:1] RESP_OK   = 2'd1;
    localparam logic [0:1] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPND2,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 datapath: add/sub with range check, logical shifts.
// err is raised for overflow, underflow and unsupported commands.
module calc1_alu
    import calc1_pkg::*;
(
    input  logic [0:3]  cmd_i,
    input  logic [0:31] op1_i,
    input  logic [0:31] op2_i,
    output logic [0:31] result_o,
    output logic        err_o
);

    // Bit 0 of the 33-bit sum is the carry out of the operand MSB.
    logic [0:32] sum;

    always_comb begin
        sum      = {1'b0, op1_i} + {1'b0, op2_i};
        result_o = '0;
        err_o    = 1'b0;
        case (cmd_i)
            CMD_ADD: begin
                if (sum[0]) err_o = 1'b1;
                else        result_o = sum[1:32];
            end
            CMD_SUB: begin
                if (op2_i > op1_i) err_o = 1'b1;
                else               result_o = op1_i - op2_i;
            end
            CMD_SHL: result_o = op1_i << op2_i[27:31];
            CMD_SHR: result_o = op1_i >> op2_i[27:31];
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// Single-port calc1 responder: two-beat request, one registered response
// beat RESP_LAT cycles after the operand-2 cycle.
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int unsigned RESP_LAT = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [0:3]  cmd_q, cmd_d;
    logic [0:31] op1_q, op1_d;
    logic [0:31] op2_q, op2_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [0:1]  resp_q, resp_d;
    logic [0:31] data_q, data_d;

    logic [0:31] alu_op2;
    logic [0:31] alu_result;
    logic        alu_err;

    calc1_alu u_alu (
        .cmd_i    (cmd_q),
        .op1_i    (op1_q),
        .op2_i    (alu_op2),
        .result_o (alu_result),
        .err_o    (alu_err)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        resp_d  = RESP_NONE;
        data_d  = '0;
        alu_op2 = op2_q;
        case (state_q)
            ST_IDLE: begin
                if (req_cmd_in != CMD_NOP) begin
                    cmd_d   = req_cmd_in;
                    op1_d   = req_data_in;
                    state_d = ST_OPND2;
                end
            end
            ST_OPND2: begin
                // Operand 2 is not yet registered here; feed the ALU directly
                // so the RESP_LAT=1 path can load the response this cycle.
                op2_d   = req_data_in;
                alu_op2 = req_data_in;
                cnt_d   = 4'(RESP_LAT - 1);
                state_d = (RESP_LAT == 1) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_RESP) begin
            resp_d = alu_err ? RESP_ERR : RESP_OK;
            data_d = alu_err ? '0 : alu_result;
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= RESP_NONE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
        end
    end

    assign out_resp = resp_q;
    assign out_data = data_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
